// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// State encoding is fixed at 3 bits so it stays stable across builds.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPEED = 3'd1,
        S_LOCK  = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } arb_state_t;

    localparam logic SPEED_SLOW = 1'b0;
    localparam logic SPEED_FAST = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr, wrapping.
// Returns the pick as one-hot, as an encoded index, and an any-request flag.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        // Offsets 1..NUM_REQ so the previous owner is considered last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[pos]) begin
                any        = 1'b1;
                idx        = IDX_W'(pos);
                grant[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ packet requesters, one packet per grant,
// round-robin order, baud change only between packets, and an idle guard gap after each packet.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int IDLE_GAP = 16,
    parameter int TIMEOUT  = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    input  logic [NUM_REQ-1:0]     req_speed,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic [7:0]             tx_data,
    output logic                   tx_send,
    input  logic                   tx_busy,
    output logic                   tx_req_speed,
    input  logic                   tx_cur_speed,
    output logic                   timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TO_W  = $clog2(TIMEOUT);
    localparam int GAP_W = $clog2(IDLE_GAP + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);

    arb_state_t           state;
    logic [IDX_W-1:0]     owner;
    logic                 last_flag;
    logic [TO_W-1:0]      to_cnt;
    logic [GAP_W-1:0]     gap_cnt;

    logic [NUM_REQ-1:0]   pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 line_ready;
    logic                 transfer;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (owner),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // UART idle and running at the baud this packet asked for.
    assign line_ready = !tx_busy && (tx_cur_speed == tx_req_speed);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready[gi] = (state == S_LOCK) && grant[gi] && line_ready;
    end

    assign transfer = req_valid[owner] && req_ready[owner];

    // The round-robin pointer doubles as the index of the current owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            grant        <= '0;
            tx_send      <= 1'b0;
            tx_data      <= '0;
            tx_req_speed <= SPEED_SLOW;
            timeout_err  <= 1'b0;
            owner        <= IDX_W'(NUM_REQ - 1);
            last_flag    <= 1'b0;
            to_cnt       <= '0;
            gap_cnt      <= '0;
        end else begin
            tx_send     <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        grant        <= pick_grant;
                        tx_req_speed <= req_speed[pick_idx];
                        owner        <= pick_idx;
                        to_cnt       <= '0;
                        state        <= S_SPEED;
                    end
                end
                S_SPEED: begin
                    if (line_ready) state <= S_LOCK;
                end
                S_LOCK: begin
                    if (transfer) begin
                        tx_data   <= req_data[{owner, 3'b000} +: 8];
                        tx_send   <= 1'b1;
                        last_flag <= req_last[owner];
                        to_cnt    <= '0;
                        state     <= S_HOLD;
                    end else if (!req_valid[owner]) begin
                        if (to_cnt == TO_LAST) begin
                            timeout_err <= 1'b1;
                            gap_cnt     <= '0;
                            state       <= S_GAP;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    // The UART may not have raised busy yet, so it is not consulted here.
                    gap_cnt <= '0;
                    state   <= last_flag ? S_GAP : S_LOCK;
                end
                S_GAP: begin
                    if (tx_busy) begin
                        gap_cnt <= '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        grant <= '0;
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter (byte-wide send/busy handshake with a two-speed baud select) between NUM_REQ packet-oriented requesters, e.g. GPS configuration, telemetry downlink, debug console. Grants the transmitter to one requester per packet with round-robin fairness. Switches baud speed only between packets and inserts an idle guard gap after each packet. Sits between the requesting controllers and the UART TX core.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
IDLE_GAP, 16, clk cycles of enforced line idle after a packet completes
TIMEOUT, 4096, clk cycles a granted requester may stall (no req_valid) before forced release

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester byte available
req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  NUM_REQ  byte on req_data is last of packet
req_speed  in  NUM_REQ  requested baud select (0 = slow, 1 = fast)
req_ready  out  NUM_REQ  byte accepted this cycle (valid&ready = transfer)
grant  out  NUM_REQ  one-hot owner of transmitter; all-zero when free
tx_data  out  8  byte to UART TX
tx_send  out  1  one-cycle send strobe
tx_busy  in  1  UART TX shifting
tx_req_speed  out  1  baud select requested from UART
tx_cur_speed  in  1  baud select currently active in UART
timeout_err  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (async, any state): state = S_IDLE; grant = 0; tx_send = 0; tx_data = 0; tx_req_speed = 0; timeout_err = 0; rr pointer = NUM_REQ-1, so requester 0 has first priority; counters = 0. Reset mid-packet abandons the packet; tx_send drops immediately.
- Outputs grant, tx_data, tx_send, tx_req_speed, timeout_err are registered.
- req_ready is combinational: req_ready[i] = (state==S_LOCK) & grant[i] & !tx_busy & (tx_cur_speed==tx_req_speed). It never depends on req_valid.
- S_IDLE:
  - If any req_valid: select the first set bit searching upward from rr pointer+1 (wrapping).
  - Register grant one-hot; set tx_req_speed = req_speed[sel] sampled this cycle; set rr pointer = sel; go to S_SPEED.
  - No requests: stay in S_IDLE.
- S_SPEED: wait until !tx_busy && tx_cur_speed==tx_req_speed, then go to S_LOCK. No timeout here.
- S_LOCK:
  - On transfer (req_valid[g] & req_ready[g]): next cycle tx_data = req_data[g], tx_send = 1. Latch req_last; go to S_HOLD.
  - Timeout counter increments each S_LOCK cycle with !req_valid[g]. It clears on transfer.
  - When the counter reaches TIMEOUT-1: pulse timeout_err, go to S_GAP.
- S_HOLD: exactly one cycle. tx_send returns to 0 and tx_busy is ignored in this cycle. Go to S_GAP if the latched last flag is set, otherwise go to S_LOCK. Throughput is at most one byte per 2 cycles plus UART busy time.
- S_GAP:
  - grant stays asserted. Counter counts cycles with !tx_busy; it resets to 0 while tx_busy is high.
  - At IDLE_GAP cycles: clear grant; go to S_IDLE.
  - The next arbitration happens no earlier than the cycle after grant clears.
- Speed changes only at the S_IDLE→S_SPEED transition. Changes to req_speed mid-packet are ignored.
- Simultaneous requests: round-robin order only. A requester that drops req_valid while in S_IDLE is not granted.
- A single-byte packet (req_last on first byte) is legal.
- Withdrawn requests are not remembered. Each byte is sent exactly once.
- Widths: timeout counter $clog2(TIMEOUT) bits; gap counter $clog2(IDLE_GAP+1) bits; counters saturate, never wrap.

Decomposition:
- Package uart_arb_pkg: state enumeration (S_IDLE, S_SPEED, S_LOCK, S_HOLD, S_GAP, 3-bit encoding) and speed constants SPEED_SLOW = 0, SPEED_FAST = 1.
- Sub-module rr_arbiter: combinational round-robin pick.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, encoded index, any.
  - Instantiated once; reused elsewhere.

Test Plan:
- Requester 0 sends 0x24,0x47,0x41 (last on 0x41), speed 0; tx_busy high 10 cycles after each send → three tx_send pulses with data in order; grant[0] drops 16 idle cycles after last busy falls.
- Requesters 0 and 1 valid simultaneously after reset, 2-byte packets each → req0 packet completes fully before grant[1]; no interleaving of bytes.
- All three continuously requesting, single-byte packets → grant order 0,1,2,0,1,2.
- Requester 2 requests speed 1 while tx_cur_speed = 0 → tx_req_speed = 1 and no tx_send until tx_cur_speed = 1 is driven; then bytes flow.
- Requester 1 granted, sends 1 byte, then drops req_valid → timeout_err pulses once at TIMEOUT cycles; grant clears after gap; requester 0 then served.
- Assert rst during S_HOLD with tx_send high → tx_send, grant, tx_req_speed all 0 same cycle; after release, requester 0 gets priority.
